// File: rtl/fifo32x6_rd_if.sv
// Handshake bundle for the 32x6 FIFO: the write side, the registered read side and the status flags.
// master = producer/consumer side, slave = FIFO.
interface fifo32x6_rd_if;
  logic [5:0] DI;
  logic       WE;
  logic       FULL;
  logic       AFULL;
  logic [5:0] DO;
  logic       DV;
  logic       RE;
  logic       AEMPTY;
  logic [5:0] COUNT;
  logic       OVF;
  logic       UNF;

  modport master (output DI, WE, RE,
                  input  FULL, AFULL, DO, DV, AEMPTY, COUNT, OVF, UNF);
  modport slave  (input  DI, WE, RE,
                  output FULL, AFULL, DO, DV, AEMPTY, COUNT, OVF, UNF);
endinterface

// File: rtl/fifo32x6_rd.sv
// 32x6 synchronous FIFO built on distributed RAM (async read), with a registered DO/DV
// output stage popped whenever it is empty or being accepted.
module fifo32x6_rd #(
  parameter int AFULL_LEVEL  = 24,
  parameter int AEMPTY_LEVEL = 4
) (
  input  logic CLK,
  input  logic RST,
  fifo32x6_rd_if.slave bus
);
  localparam logic [5:0] AF_LVL = AFULL_LEVEL[5:0];
  localparam logic [5:0] AE_LVL = AEMPTY_LEVEL[5:0];

  logic [5:0] mem [32];

  logic [4:0] wptr_q, wptr_d;
  logic [4:0] rptr_q, rptr_d;
  logic [5:0] count_q, count_d;
  logic [5:0] do_q, do_d;
  logic       dv_q, dv_d;
  logic       ovf_q, ovf_d;
  logic       unf_q, unf_d;

  logic full, wr_acc, pop;

  assign full   = (count_q == 6'd32);
  assign wr_acc = bus.WE && !full;
  // Pop uses the registered count, so a word written into an empty RAM waits one cycle.
  assign pop    = (count_q != 6'd0) && (!dv_q || bus.RE);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    do_d    = do_q;
    dv_d    = dv_q;
    ovf_d   = ovf_q | (bus.WE && full);
    unf_d   = unf_q | (bus.RE && !dv_q);
    count_d = count_q + {5'd0, wr_acc} - {5'd0, pop};
    if (wr_acc) wptr_d = wptr_q + 5'd1;
    if (pop) begin
      do_d   = mem[rptr_q];
      rptr_d = rptr_q + 5'd1;
      dv_d   = 1'b1;
    end else if (bus.RE && dv_q) begin
      dv_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      do_q    <= '0;
      dv_q    <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      do_q    <= do_d;
      dv_q    <= dv_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // RAM contents are deliberately not reset so this maps onto LUT RAM.
  always_ff @(posedge CLK) begin
    if (wr_acc && !RST) mem[wptr_q] <= bus.DI;
  end

  assign bus.FULL   = full;
  assign bus.AFULL  = (count_q >= AF_LVL);
  assign bus.AEMPTY = (count_q <= AE_LVL);
  assign bus.COUNT  = count_q;
  assign bus.DO     = do_q;
  assign bus.DV     = dv_q;
  assign bus.OVF    = ovf_q;
  assign bus.UNF    = unf_q;
endmodule

// File: tb/tb_fifo32x6_rd.sv
// Directed bench for fifo32x6_rd: inputs change 1ns after each rising edge, outputs are checked there.
module tb_fifo32x6_rd;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int checks = 0;
  int errors = 0;

  fifo32x6_rd_if bus();
  fifo32x6_rd #(.AFULL_LEVEL(24), .AEMPTY_LEVEL(4)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1; bus.WE = 1'b0; bus.RE = 1'b0; bus.DI = '0;
    tick(); tick();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.DV !== 1'b0) begin errors++; $display("FAIL reset_dv got %0h exp 0", bus.DV); end
    checks++; if (bus.DO !== 6'h00) begin errors++; $display("FAIL reset_do got %0h exp 0", bus.DO); end
    checks++; if (bus.COUNT !== 6'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", bus.COUNT); end
    checks++; if (bus.FULL !== 1'b0) begin errors++; $display("FAIL reset_full got %0h exp 0", bus.FULL); end
    checks++; if (bus.AFULL !== 1'b0) begin errors++; $display("FAIL reset_afull got %0h exp 0", bus.AFULL); end
    checks++; if (bus.AEMPTY !== 1'b1) begin errors++; $display("FAIL reset_aempty got %0h exp 1", bus.AEMPTY); end
    checks++; if (bus.OVF !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0h exp 0", bus.OVF); end
    checks++; if (bus.UNF !== 1'b0) begin errors++; $display("FAIL reset_unf got %0h exp 0", bus.UNF); end
  endtask

  task automatic test_single();
    bus.WE = 1'b1; bus.DI = 6'h2A; tick();
    bus.WE = 1'b0;
    checks++; if (bus.COUNT !== 6'd1) begin errors++; $display("FAIL single_count1 got %0d exp 1", bus.COUNT); end
    checks++; if (bus.DV !== 1'b0) begin errors++; $display("FAIL single_nobypass got %0h exp 0", bus.DV); end
    tick();
    checks++; if (bus.DV !== 1'b1) begin errors++; $display("FAIL single_dv got %0h exp 1", bus.DV); end
    checks++; if (bus.DO !== 6'h2A) begin errors++; $display("FAIL single_do got %0h exp 2a", bus.DO); end
    checks++; if (bus.COUNT !== 6'd0) begin errors++; $display("FAIL single_count0 got %0d exp 0", bus.COUNT); end
    tick();
    checks++; if (bus.DV !== 1'b1) begin errors++; $display("FAIL single_hold got %0h exp 1", bus.DV); end
    bus.RE = 1'b1; tick();
    bus.RE = 1'b0;
    checks++; if (bus.DV !== 1'b0) begin errors++; $display("FAIL single_retire got %0h exp 0", bus.DV); end
    checks++; if (bus.DO !== 6'h2A) begin errors++; $display("FAIL single_do_keep got %0h exp 2a", bus.DO); end
  endtask

  task automatic test_fill_overflow();
    logic [5:0] exp_cnt;
    do_reset();
    for (int i = 0; i < 34; i++) begin
      bus.WE = 1'b1; bus.DI = 6'(i); tick();
      exp_cnt = (i == 0) ? 6'd1 : (i > 32) ? 6'd32 : 6'(i);
      checks++; if (bus.COUNT !== exp_cnt) begin errors++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, bus.COUNT, exp_cnt); end
      checks++; if (bus.AFULL !== (exp_cnt >= 6'd24)) begin errors++; $display("FAIL fill_afull[%0d] got %0h exp %0h", i, bus.AFULL, exp_cnt >= 6'd24); end
      checks++; if (bus.AEMPTY !== (exp_cnt <= 6'd4)) begin errors++; $display("FAIL fill_aempty[%0d] got %0h exp %0h", i, bus.AEMPTY, exp_cnt <= 6'd4); end
      checks++; if (bus.FULL !== (exp_cnt == 6'd32)) begin errors++; $display("FAIL fill_full[%0d] got %0h exp %0h", i, bus.FULL, exp_cnt == 6'd32); end
      checks++; if (bus.OVF !== (i == 33)) begin errors++; $display("FAIL fill_ovf[%0d] got %0h exp %0h", i, bus.OVF, i == 33); end
    end
    bus.WE = 1'b0;
    for (int k = 0; k < 33; k++) begin
      checks++; if (bus.DV !== 1'b1 || bus.DO !== 6'(k)) begin errors++; $display("FAIL drain[%0d] got dv=%0h do=%0d exp dv=1 do=%0d", k, bus.DV, bus.DO, k); end
      bus.RE = 1'b1; tick();
    end
    bus.RE = 1'b0;
    checks++; if (bus.DV !== 1'b0) begin errors++; $display("FAIL drain_end_dv got %0h exp 0", bus.DV); end
    checks++; if (bus.COUNT !== 6'd0) begin errors++; $display("FAIL drain_end_count got %0d exp 0", bus.COUNT); end
  endtask

  task automatic test_underflow();
    do_reset();
    bus.RE = 1'b1; tick();
    bus.RE = 1'b0;
    checks++; if (bus.UNF !== 1'b1) begin errors++; $display("FAIL unf_set got %0h exp 1", bus.UNF); end
    checks++; if (bus.DV !== 1'b0) begin errors++; $display("FAIL unf_dv got %0h exp 0", bus.DV); end
    tick();
    checks++; if (bus.UNF !== 1'b1) begin errors++; $display("FAIL unf_sticky got %0h exp 1", bus.UNF); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.RE = 1'b1;
    for (int i = 0; i < 100; i++) begin
      bus.WE = 1'b1; bus.DI = 6'(i % 64); tick();
      if (i > 0) begin
        checks++; if (bus.DV !== 1'b1 || bus.DO !== 6'((i - 1) % 64)) begin errors++; $display("FAIL stream[%0d] got dv=%0h do=%0d exp dv=1 do=%0d", i, bus.DV, bus.DO, (i - 1) % 64); end
      end
      checks++; if (bus.COUNT > 6'd1) begin errors++; $display("FAIL stream_count[%0d] got %0d exp <=1", i, bus.COUNT); end
    end
    bus.WE = 1'b0; tick();
    checks++; if (bus.DV !== 1'b1 || bus.DO !== 6'd35) begin errors++; $display("FAIL stream_last got dv=%0h do=%0d exp dv=1 do=35", bus.DV, bus.DO); end
    tick();
    bus.RE = 1'b0;
    checks++; if (bus.DV !== 1'b0 || bus.COUNT !== 6'd0) begin errors++; $display("FAIL stream_empty got dv=%0h cnt=%0d exp 0 0", bus.DV, bus.COUNT); end
  endtask

  task automatic test_full_simul();
    do_reset();
    for (int i = 0; i < 33; i++) begin
      bus.WE = 1'b1; bus.DI = 6'(i + 10); tick();
    end
    checks++; if (bus.COUNT !== 6'd32 || bus.DV !== 1'b1 || bus.OVF !== 1'b0) begin errors++; $display("FAIL simul_pre got cnt=%0d dv=%0h ovf=%0h exp 32 1 0", bus.COUNT, bus.DV, bus.OVF); end
    bus.WE = 1'b1; bus.DI = 6'h3F; bus.RE = 1'b1; tick();
    bus.WE = 1'b0; bus.RE = 1'b0;
    checks++; if (bus.OVF !== 1'b1) begin errors++; $display("FAIL simul_ovf got %0h exp 1", bus.OVF); end
    checks++; if (bus.COUNT !== 6'd31) begin errors++; $display("FAIL simul_count got %0d exp 31", bus.COUNT); end
    checks++; if (bus.DO !== 6'd11 || bus.DV !== 1'b1) begin errors++; $display("FAIL simul_next got do=%0d dv=%0h exp 11 1", bus.DO, bus.DV); end
    for (int k = 1; k < 33; k++) begin
      checks++; if (bus.DV !== 1'b1 || bus.DO !== 6'(k + 10)) begin errors++; $display("FAIL simul_drain[%0d] got dv=%0h do=%0d exp 1 %0d", k, bus.DV, bus.DO, k + 10); end
      bus.RE = 1'b1; tick();
    end
    bus.RE = 1'b0;
    checks++; if (bus.DV !== 1'b0) begin errors++; $display("FAIL simul_dropped got dv=%0h exp 0", bus.DV); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 11; i++) begin
      bus.WE = 1'b1; bus.DI = 6'(40 + i); tick();
    end
    bus.WE = 1'b0;
    checks++; if (bus.COUNT !== 6'd10 || bus.DV !== 1'b1) begin errors++; $display("FAIL mid_pre got cnt=%0d dv=%0h exp 10 1", bus.COUNT, bus.DV); end
    RST = 1'b1; bus.WE = 1'b1; bus.DI = 6'd7; bus.RE = 1'b1; tick();
    RST = 1'b0; bus.WE = 1'b0; bus.RE = 1'b0;
    checks++; if (bus.COUNT !== 6'd0 || bus.DV !== 1'b0 || bus.DO !== 6'd0) begin errors++; $display("FAIL mid_rst got cnt=%0d dv=%0h do=%0d exp 0 0 0", bus.COUNT, bus.DV, bus.DO); end
    bus.WE = 1'b1; bus.DI = 6'd21; tick();
    bus.WE = 1'b0; tick();
    checks++; if (bus.DV !== 1'b1 || bus.DO !== 6'd21) begin errors++; $display("FAIL mid_first got dv=%0h do=%0d exp 1 21", bus.DV, bus.DO); end
    checks++; if (bus.COUNT !== 6'd0) begin errors++; $display("FAIL mid_count got %0d exp 0", bus.COUNT); end
  endtask

  initial begin
    bus.WE = 1'b0; bus.RE = 1'b0; bus.DI = '0;
    test_reset();
    test_single();
    test_fill_overflow();
    test_underflow();
    test_back_to_back();
    test_full_simul();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
